seg7_scan: RTL
==============

# seg7_scan

Parametrised, time-multiplexed seven-segment display controller for the board's common-anode display bank. It takes a packed hex nibble per digit, a decimal-point mask and a blank mask, scans one digit at a time at a programmable rate, and drives active-low segment and anode lines. Display data is double-buffered: new data is committed only at a frame boundary, so the display never tears. It sits between the reseller control logic and the `ca..cg`, `dp` and `an` board pins.

## Interface
- `DIGITS`, default 8: number of digits. Must be ≥ 2.
- `SCAN_DIV`, default 100000: clocks per digit slot. Must be ≥ 2. At 100 MHz this gives 1 kHz per digit.
- `clk` in, 1 bit: system clock. The block has one clock.
- `rst` in, 1 bit: reset, asynchronous and active-high.
- `data` in, 4*DIGITS bits: hex nibbles. Nibble i (`data[4i+3:4i]`) drives digit i, and digit 0 is the rightmost.
- `dp_in` in, DIGITS bits: decimal-point enable per digit, active-high.
- `blank` in, DIGITS bits: forces the digit dark, active-high.
- `load` in, 1 bit: one-cycle strobe that captures `data`, `dp_in` and `blank` into the shadow register.
- `pending` out, 1 bit: high while the shadow holds data that has not yet been committed.
- `frame` out, 1 bit: one-cycle pulse on every frame boundary.
- `ca, cb, cc, cd, ce, cf, cg, dp` out, 1 bit each: segment lines, active-low.
- `an` out, DIGITS bits: anode selects, active-low, exactly one low at a time or none.

## Operation
- **Prescaler `cnt`:**
  - Range 0..SCAN_DIV-1; width `$clog2(SCAN_DIV)`.
  - The internal `tick` is asserted when `cnt == SCAN_DIV-1`; `cnt` then wraps to 0.
- **Digit index `idx`:**
  - Width `$clog2(DIGITS)`.
  - Increments on `tick`; after DIGITS-1 it wraps to 0.
  - The wrap cycle is the frame boundary and produces `frame`.
- **Shadow register:**
  - On `load`, `data`, `dp_in` and `blank` are captured into the shadow and `pending` is set to 1.
  - A later `load` while `pending` is high overwrites the shadow; the latest load wins.
- **Commit:**
  - On a frame boundary with `pending` = 1, the shadow is copied to the display register and `pending` is cleared.
  - If `load` and a commit fall in the same cycle, the old shadow is committed, the new values are captured, and `pending` stays 1.
- **Hex decode:** active-high patterns a..g, then inverted onto the pins.
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- **Blanked digit:** its anode stays 1 for the whole slot, and the segments and `dp` are 1.

## Timing
- **Reset values** (applied asynchronously):
  - `cnt`=0, `idx`=0
  - display and shadow registers = 0, `pending`=0, `frame`=0
  - all segment lines and `dp` = 1, `an` = all 1s
- **Outputs are registered.** Segment lines, `dp` and `an` reflect `idx` one clock after `idx` changes.
- **First frame after reset:**
  - First clock edge after `rst` falls: `an` = ~(1<<0), showing the reset display contents (all 0, so digit 0 shows "0").
- **`frame`** is registered and is high for exactly one clock, in the cycle after the wrap tick.
- **Load-to-display latency:** at most one full frame (DIGITS*SCAN_DIV clocks) plus 2 clocks.
- **Reset mid-frame:** the display goes dark immediately and any pending data is discarded.

## Configuration
- **`SEG7_LEADING_ZERO_BLANK_EN` defined:** zero digits more significant than the highest non-zero digit are blanked. Digit 0 is never suppressed. The blank mask is still applied (OR-combined).
- **Not defined:** only `blank` suppresses digits, and all zeros are displayed.

## Structure
- **Package `seg7_pkg`:**
  - the 16-entry active-high segment constants `SEG_HEX_0..SEG_HEX_F`
  - the `seg_t` typedef (7 bits, a..g)
  - the `hex_to_seg` function
- **Sub-module `seg7_hexdec`:** combinational nibble → `seg_t` decoder, instantiated once on the selected nibble.
- The prescaler, index, double buffer and leading-zero logic live in `seg7_scan`.

## Test plan
Benches use `DIGITS`=8 and `SCAN_DIV`=4.
1. **Reset:** assert `rst` → all segment lines, `dp` and `an` = 1, `pending`=0, `frame`=0. Release → next edge `an`=8'hFE, `{ca..cg}`=0000001 (digit 0 shows "0"). Then `frame` pulses every 32 clocks.
2. **Load 32'h12345678:**
   - `pending` goes high.
   - After the next frame boundary `pending`=0.
   - Slot 0: `an`=8'hFE, `{ca..cg}`=0000000 ("8").
   - Slot 7: `an`=8'h7F, `{ca..cg}`=1001111 ("1").
3. **Load mid-frame** (at `idx`=3) with 32'hFFFFFFFF → slots 4..7 still show the old data. The new data appears from slot 0 of the next frame, and `pending` falls with `frame`.
4. **Two loads before a boundary** (32'h11111111, then 32'h22222222) → only "2" is ever displayed. Also drive `load` on the commit cycle itself → `pending` remains 1 afterwards.
5. **Masks:** `blank`=8'h08 → `an[3]` is never 0. `dp_in`=8'h01 → `dp`=0 only during slot 0.
6. **Leading-zero blanking:** with `SEG7_LEADING_ZERO_BLANK_EN` and data 32'h000000A0 → digits 2..7 dark, digit 1 = 0001000 ("A"), digit 0 = 0000001 ("0"). Without the macro, all eight digits are lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and hex-to-segment constants for the seven-segment scan controller.
// Segment vectors are active-high, bit 6 = segment a down to bit 0 = segment g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_HEX_0 = 7'b1111110;
  localparam seg_t SEG_HEX_1 = 7'b0110000;
  localparam seg_t SEG_HEX_2 = 7'b1101101;
  localparam seg_t SEG_HEX_3 = 7'b1111001;
  localparam seg_t SEG_HEX_4 = 7'b0110011;
  localparam seg_t SEG_HEX_5 = 7'b1011011;
  localparam seg_t SEG_HEX_6 = 7'b1011111;
  localparam seg_t SEG_HEX_7 = 7'b1110000;
  localparam seg_t SEG_HEX_8 = 7'b1111111;
  localparam seg_t SEG_HEX_9 = 7'b1111011;
  localparam seg_t SEG_HEX_A = 7'b1110111;
  localparam seg_t SEG_HEX_B = 7'b0011111;
  localparam seg_t SEG_HEX_C = 7'b1001110;
  localparam seg_t SEG_HEX_D = 7'b0111101;
  localparam seg_t SEG_HEX_E = 7'b1001111;
  localparam seg_t SEG_HEX_F = 7'b1000111;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    unique case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment controller with frame-synchronous double buffering.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never).
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame,
  output logic                  ca,
  output logic                  cb,
  output logic                  cc,
  output logic                  cd,
  output logic                  ce,
  output logic                  cf,
  output logic                  cg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tick, wrap;

  logic [DIGITS-1:0][3:0] sh_data_q, disp_data_q;
  logic [DIGITS-1:0]      sh_dp_q, sh_blank_q, disp_dp_q, disp_blank_q;
  logic                   pending_q, pending_d, frame_q;

  logic [DIGITS-1:0] lz_blank;
  logic [3:0]        cur_nib;
  seg_t              cur_seg;
  logic              cur_off;

  seg_t              seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  // Prescaler and digit index
  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= wrap;
    end
  end

  // A load coinciding with a commit keeps pending set: the old shadow is committed first.
  assign pending_d = load ? 1'b1 : (wrap ? 1'b0 : pending_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_data_q    <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      if (wrap && pending_q) begin
        disp_data_q  <= sh_data_q;
        disp_dp_q    <= sh_dp_q;
        disp_blank_q <= sh_blank_q;
      end
      if (load) begin
        sh_data_q  <= data;
        sh_dp_q    <= dp_in;
        sh_blank_q <= blank;
      end
      pending_q <= pending_d;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic nz_seen;
`endif

  always_comb begin
    lz_blank = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Scan from the most significant digit down; suppress until a non-zero nibble appears.
    nz_seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz_seen     = nz_seen | (disp_data_q[i] != 4'h0);
      lz_blank[i] = ~nz_seen;
    end
`endif
  end

  seg7_hexdec u_hexdec (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  always_comb begin
    cur_nib = disp_data_q[idx_q];
    cur_off = disp_blank_q[idx_q] | lz_blank[idx_q];
    an_d    = '1;
    if (!cur_off) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d = cur_off ? '1 : ~cur_seg;
    dp_d  = cur_off | ~disp_dp_q[idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= '1;
      dp_q  <= 1'b1;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      dp_q  <= dp_d;
      an_q  <= an_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign ca      = seg_q[6];
  assign cb      = seg_q[5];
  assign cc      = seg_q[4];
  assign cd      = seg_q[3];
  assign ce      = seg_q[2];
  assign cf      = seg_q[1];
  assign cg      = seg_q[0];
  assign dp      = dp_q;
  assign an      = an_q;

endmodule
